// File: rtl/datamem_pkg.sv
// Shared types and helpers for the byte-addressable data memory controller:
// FSM state encoding, legal transfer sizes and load-result extension.
package datamem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    localparam logic [3:0] SIZE_B = 4'd1;
    localparam logic [3:0] SIZE_H = 4'd2;
    localparam logic [3:0] SIZE_W = 4'd4;
    localparam logic [3:0] SIZE_D = 4'd8;

    function automatic logic size_legal(input logic [3:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) || (size == SIZE_D);
    endfunction

    // Bits above the transfer width are filled with the top data bit or zero.
    function automatic logic [63:0] extend(input logic [63:0] data, input logic [3:0] size,
                                           input logic sgn);
        logic [63:0] r;
        case (size)
            SIZE_B:  r = {{56{sgn & data[7]}},  data[7:0]};
            SIZE_H:  r = {{48{sgn & data[15]}}, data[15:0]};
            SIZE_W:  r = {{32{sgn & data[31]}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/datamem_if.sv
// Request/response bus between a requester (master) and the data memory
// controller (slave).
interface datamem_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_size;
    logic              req_signed;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/datamem_array.sv
// Word-wide RAM with per-byte write enables; read data is registered on every
// enabled access cycle and returns the pre-write contents.
module datamem_array #(
    parameter int WORDS = 128,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       be,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);
    logic [63:0] mem [WORDS];

    // No reset: contents survive reset and stay undefined until written.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/datamem_ctrl.sv
// Serialising load/store controller: unaligned accesses that straddle a word
// are split into two beats, with byte-lane shifting and load extension here.
module datamem_ctrl
    import datamem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic clk,
    input  logic reset_n,
    datamem_if.slave bus
);
    localparam int WORDS = MEM_BYTES / 8;
    localparam int IDX_W = $clog2(WORDS);

    if (MEM_BYTES <= 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_size
        $error("MEM_BYTES must be a power of two greater than 8");
    end

    state_t           state;
    logic             write_q;
    logic             signed_q;
    logic             split_q;
    logic [3:0]       size_q;
    logic [2:0]       off_q;
    logic [IDX_W-1:0] word_q;
    logic [63:0]      wdata_q;
    logic [63:0]      lo_q;

    logic             accept;
    logic [ADDR_W:0]  end_addr;
    logic             req_err;
    logic             req_split;

    logic             mem_en;
    logic [IDX_W-1:0] mem_addr;
    logic [7:0]       mem_be;
    logic [63:0]      mem_wdata;
    logic [63:0]      rd;

    logic [7:0]       lane;
    logic [15:0]      mask;
    logic [127:0]     wide;
    logic [127:0]     pair;
    logic [63:0]      load_data;

    assign accept    = bus.req_valid && bus.req_ready;
    // One extra bit so addresses near the top of the address space cannot wrap.
    assign end_addr  = {1'b0, bus.req_addr} + (ADDR_W+1)'(bus.req_size);
    assign req_err   = !size_legal(bus.req_size) || (end_addr > (ADDR_W+1)'(MEM_BYTES));
    assign req_split = ({2'b00, bus.req_addr[2:0]} + {1'b0, bus.req_size}) > 5'd8;

    always_comb begin
        case (size_q)
            SIZE_B:  lane = 8'h01;
            SIZE_H:  lane = 8'h03;
            SIZE_W:  lane = 8'h0F;
            default: lane = 8'hFF;
        endcase
    end

    // Two-word window: low half is the BEAT0 word, high half the BEAT1 word.
    assign mask = {8'h00, lane} << off_q;
    assign wide = {64'h0, wdata_q} << {off_q, 3'b000};

    always_comb begin
        mem_en    = (state == BEAT0) || (state == BEAT1);
        mem_addr  = (state == BEAT1) ? word_q + IDX_W'(1) : word_q;
        mem_be    = '0;
        mem_wdata = (state == BEAT1) ? wide[127:64] : wide[63:0];
        if (write_q) mem_be = (state == BEAT1) ? mask[15:8] : mask[7:0];
    end

    datamem_array #(.WORDS(WORDS)) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (write_q),
        .addr  (mem_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (rd)
    );

    assign pair      = {split_q ? rd : 64'h0, split_q ? lo_q : rd};
    assign load_data = 64'(pair >> {off_q, 3'b000});

    assign bus.resp_rdata = (bus.resp_valid && !bus.resp_err && !write_q)
                          ? extend(load_data, size_q, signed_q) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            write_q        <= 1'b0;
            signed_q       <= 1'b0;
            split_q        <= 1'b0;
            size_q         <= '0;
            off_q          <= '0;
            word_q         <= '0;
            wdata_q        <= '0;
            lo_q           <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        write_q       <= bus.req_write;
                        signed_q      <= bus.req_signed;
                        split_q       <= req_split;
                        size_q        <= bus.req_size;
                        off_q         <= bus.req_addr[2:0];
                        word_q        <= bus.req_addr[IDX_W+2:3];
                        wdata_q       <= bus.req_wdata;
                        if (req_err) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state <= BEAT0;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                BEAT0: begin
                    if (split_q) begin
                        state <= BEAT1;
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                    end
                end
                BEAT1: begin
                    lo_q           <= rd;
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed self-checking bench for datamem_ctrl: aligned, split, sign-extended,
// error, back-to-back and reset-during-split scenarios.
module tb_datamem_ctrl;
    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   passes   = 0;
    int   idle_bad = 0;

    datamem_if #(.ADDR_W(64)) bus ();

    datamem_ctrl #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request, scrambles the inputs after acceptance, and returns
    // the response together with the cycle count from acceptance.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                          input logic sgn, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            rdata = '0;
            err   = 1'b0;
            lat   = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_write  = ~wr;
        bus.req_addr   = ~addr;
        bus.req_size   = 4'd3;
        bus.req_signed = ~sgn;
        bus.req_wdata  = ~wdata;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            if (bus.resp_rdata !== 64'h0 || bus.resp_err !== 1'b0) idle_bad++;
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) lat = -1;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = '0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.req_ready); else passes++;
        checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.resp_valid); else passes++;
        checks++; if (bus.resp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.resp_err); else passes++;
        checks++; if (bus.resp_rdata !== 64'h0) $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_release_ready: got %b want 0", bus.req_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_first_edge_ready: got %b want 1", bus.req_ready); else passes++;
    endtask

    task automatic test_store_load8();
        logic [63:0] rd; logic err; int lat;
        do_req(1'b1, 64'h10, 4'd8, 1'b0, 64'h1122334455667788, rd, err, lat);
        checks++; if (lat !== 2) $display("FAIL st8_lat: got %0d want 2", lat); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL st8_err: got %b want 0", err); else passes++;
        checks++; if (rd !== 64'h0) $display("FAIL st8_rdata: got %h want 0", rd); else passes++;
        do_req(1'b0, 64'h10, 4'd8, 1'b0, 64'h0, rd, err, lat);
        checks++; if (lat !== 2) $display("FAIL ld8_lat: got %0d want 2", lat); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL ld8_err: got %b want 0", err); else passes++;
        checks++; if (rd !== 64'h1122334455667788) $display("FAIL ld8_rdata: got %h want 1122334455667788", rd); else passes++;
    endtask

    task automatic test_split();
        logic [63:0] rd; logic err; int lat;
        do_req(1'b1, 64'h08, 4'd8, 1'b0, 64'h0706050403020100, rd, err, lat);
        do_req(1'b1, 64'h0E, 4'd4, 1'b0, 64'h99887766AABBCCDD, rd, err, lat);
        checks++; if (lat !== 3) $display("FAIL split_st_lat: got %0d want 3", lat); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL split_st_err: got %b want 0", err); else passes++;
        do_req(1'b0, 64'h08, 4'd8, 1'b0, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'hCCDD050403020100) $display("FAIL split_word08: got %h want ccdd050403020100", rd); else passes++;
        do_req(1'b0, 64'h10, 4'd8, 1'b0, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'h112233445566AABB) $display("FAIL split_word10: got %h want 112233445566aabb", rd); else passes++;
        do_req(1'b0, 64'h0E, 4'd4, 1'b0, 64'h0, rd, err, lat);
        checks++; if (lat !== 3) $display("FAIL split_ld_lat: got %0d want 3", lat); else passes++;
        checks++; if (rd !== 64'h00000000AABBCCDD) $display("FAIL split_ld_u: got %h want aabbccdd", rd); else passes++;
        do_req(1'b0, 64'h0E, 4'd4, 1'b1, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'hFFFFFFFFAABBCCDD) $display("FAIL split_ld_s: got %h want ffffffffaabbccdd", rd); else passes++;
    endtask

    task automatic test_sign_ext();
        logic [63:0] rd; logic err; int lat;
        do_req(1'b1, 64'h20, 4'd8, 1'b0, 64'h0123456789ABCDEF, rd, err, lat);
        do_req(1'b1, 64'h20, 4'd1, 1'b0, 64'hDEADBEEFCAFE1280, rd, err, lat);
        do_req(1'b0, 64'h20, 4'd8, 1'b1, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'h0123456789ABCD80) $display("FAIL byte_store_only: got %h want 0123456789abcd80", rd); else passes++;
        do_req(1'b0, 64'h20, 4'd1, 1'b1, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFF80) $display("FAIL ld1_signed: got %h want ffffffffffffff80", rd); else passes++;
        do_req(1'b0, 64'h20, 4'd1, 1'b0, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'h0000000000000080) $display("FAIL ld1_unsigned: got %h want 80", rd); else passes++;
        do_req(1'b0, 64'h21, 4'd2, 1'b1, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'hFFFFFFFFFFFFABCD) $display("FAIL ld2_signed: got %h want ffffffffffffabcd", rd); else passes++;
        do_req(1'b0, 64'h20, 4'd4, 1'b1, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'hFFFFFFFF89ABCD80) $display("FAIL ld4_signed: got %h want ffffffff89abcd80", rd); else passes++;
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic err; int lat;
        do_req(1'b1, 64'd1016, 4'd8, 1'b0, 64'h8877665544332211, rd, err, lat);
        do_req(1'b0, 64'h0, 4'd3, 1'b0, 64'h0, rd, err, lat);
        checks++; if (err !== 1'b1) $display("FAIL size3_err: got %b want 1", err); else passes++;
        checks++; if (lat !== 1) $display("FAIL size3_lat: got %0d want 1", lat); else passes++;
        checks++; if (rd !== 64'h0) $display("FAIL size3_rdata: got %h want 0", rd); else passes++;
        do_req(1'b1, 64'd1020, 4'd8, 1'b0, 64'hFFFFFFFFFFFFFFFF, rd, err, lat);
        checks++; if (err !== 1'b1) $display("FAIL oob_st_err: got %b want 1", err); else passes++;
        checks++; if (lat !== 1) $display("FAIL oob_st_lat: got %0d want 1", lat); else passes++;
        do_req(1'b0, 64'd1016, 4'd8, 1'b0, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'h8877665544332211) $display("FAIL oob_unchanged: got %h want 8877665544332211", rd); else passes++;
        do_req(1'b0, 64'd1020, 4'd4, 1'b0, 64'h0, rd, err, lat);
        checks++; if (err !== 1'b0 || rd !== 64'h88776655) $display("FAIL top_edge_ld: got err=%b %h want err=0 88776655", err, rd); else passes++;
        do_req(1'b0, 64'd1024, 4'd1, 1'b0, 64'h0, rd, err, lat);
        checks++; if (err !== 1'b1) $display("FAIL past_end_err: got %b want 1", err); else passes++;
        do_req(1'b0, 64'h8, 4'd0, 1'b0, 64'h0, rd, err, lat);
        checks++; if (err !== 1'b1) $display("FAIL size0_err: got %b want 1", err); else passes++;
    endtask

    task automatic test_back_to_back();
        int accepts = 0, resps = 0, outstanding = 0, bad = 0, rbad = 0, lbad = 0, acc_i = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 64'h0E;
        bus.req_size   = 4'd4;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 60 && resps < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (accepts == 3) bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                resps++;
                outstanding--;
                if (bus.resp_rdata !== 64'hAABBCCDD) rbad++;
                if (i - acc_i != 3) lbad++;
            end
            if (bus.req_ready && (outstanding != 0 || bus.resp_valid)) bad++;
            if (bus.req_valid && bus.req_ready) begin
                accepts++;
                outstanding++;
                acc_i = i;
            end
        end
        bus.req_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) resps++;
        end
        checks++; if (accepts !== 3) $display("FAIL b2b_accepts: got %0d want 3", accepts); else passes++;
        checks++; if (resps !== 3) $display("FAIL b2b_resps: got %0d want 3", resps); else passes++;
        checks++; if (bad !== 0) $display("FAIL b2b_ready_busy: got %0d want 0", bad); else passes++;
        checks++; if (rbad !== 0) $display("FAIL b2b_rdata: got %0d bad want 0", rbad); else passes++;
        checks++; if (lbad !== 0) $display("FAIL b2b_latency: got %0d bad want 0", lbad); else passes++;
    endtask

    task automatic test_reset_split();
        logic [63:0] rd; logic err; int lat; int seen = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 64'h0E;
        bus.req_size   = 4'd4;
        bus.req_signed = 1'b0;
        bus.req_wdata  = 64'h11223344;
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (bus.resp_valid) seen++;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rs_ready_async: got %b want 0", bus.req_ready); else passes++;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rs_no_resp: got %0d pulses want 0", seen); else passes++;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rs_release_ready: got %b want 0", bus.req_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rs_edge_ready: got %b want 1", bus.req_ready); else passes++;
        do_req(1'b0, 64'h08, 4'd8, 1'b0, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'h3344050403020100) $display("FAIL rs_beat0_written: got %h want 3344050403020100", rd); else passes++;
        do_req(1'b0, 64'h10, 4'd8, 1'b0, 64'h0, rd, err, lat);
        checks++; if (rd !== 64'h112233445566AABB) $display("FAIL rs_beat1_kept: got %h want 112233445566aabb", rd); else passes++;
    endtask

    task automatic test_idle_outputs();
        checks++; if (idle_bad !== 0) $display("FAIL idle_outputs: got %0d nonzero cycles want 0", idle_bad); else passes++;
    endtask

    initial begin
        test_reset();
        test_store_load8();
        test_split();
        test_sign_ext();
        test_errors();
        test_back_to_back();
        test_reset_split();
        test_idle_outputs();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/datamem_ctrl.md
DATAMEM_CTRL -- requirements
Module: datamem_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 1024, memory size in bytes; SHALL be a power of two and >8 (elaboration assertion).
REQ-002 Parameter ADDR_W, default 64, request address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address; any alignment is allowed.
REQ-009 req_size  input  4  transfer bytes: 1, 2, 4 or 8.
REQ-010 req_signed  input  1  load result sign-extended (1) or zero-extended (0).
REQ-011 req_wdata  input  64  store data, little-endian, low req_size bytes used.
REQ-012 resp_valid  output  1  one-cycle completion pulse, for loads and stores.
REQ-013 resp_rdata  output  64  load result, valid with resp_valid; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected, valid with resp_valid.

Function
REQ-015 Storage: MEM_BYTES/8 little-endian 64-bit words with per-byte write enables; byte k of the word at address A is memory byte A+k.
REQ-016 Handshake: a request is accepted on a cycle where req_valid && req_ready; req_ready SHALL be 1 only in IDLE; one request is outstanding at a time.
REQ-017 FSM states IDLE, BEAT0, BEAT1, RESP; IDLE->BEAT0 on accept; BEAT0->BEAT1 if the access crosses an 8-byte boundary, else BEAT0->RESP; BEAT1->RESP; RESP->IDLE.
REQ-018 Error: if req_size is not in {1,2,4,8}, or req_addr+req_size > MEM_BYTES, the request SHALL go IDLE->RESP with resp_err=1, no memory access, and resp_rdata=0.
REQ-019 Latency: for acceptance in cycle N, resp_valid SHALL be 1 in cycle N+2 for a single-beat access, N+3 for a split access, and N+1 for an error.
REQ-020 Split access: BEAT0 accesses the word containing req_addr (bytes from req_addr to the word end); BEAT1 accesses the next word (remaining bytes).
REQ-021 Stores: only the req_size addressed bytes SHALL change; all other bytes keep their values.
REQ-022 Loads: the addressed bytes are assembled little-endian into the low req_size*8 bits; upper bits are filled with copies of bit (req_size*8-1) if req_signed, else with 0; req_size=8 is unaffected by req_signed.
REQ-023 Request fields SHALL be captured on accept; input changes after accept have no effect.
REQ-024 Outputs resp_rdata and resp_err SHALL hold 0 whenever resp_valid=0.
REQ-025 A load following a store returns the stored data (no read-after-write hazard, since requests are serialised).

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force state to IDLE, resp_valid=0, resp_err=0, resp_rdata=0 and req_ready=0; req_ready SHALL go to 1 on the first clk edge after release.
REQ-027 Memory contents SHALL NOT be reset; they are X until written.
REQ-028 Reset during BEAT1 of a split store leaves the BEAT0 bytes written and the BEAT1 bytes unchanged; no response is issued.

Structure
REQ-029 Package datamem_pkg SHALL hold the FSM state enum, the legal size constants (1, 2, 4, 8), and the sign/zero-extension function.
REQ-030 Sub-module datamem_array SHALL implement the word-wide RAM with byte enables, synchronous write, and read data registered on the access cycle.
REQ-031 Split-address and byte-lane shift logic SHALL be in datamem_ctrl.

Verification
REQ-032 Store size 8 to addr 0x10 with data 0x1122334455667788, then load size 8 from 0x10 -> rdata 0x1122334455667788, err=0, resp_valid at N+2.
REQ-033 Store size 4 to 0x0E with data 0xAABBCCDD (split), then load 8 from 0x08 and load 8 from 0x10 -> bytes 0x0E=DD, 0x0F=CC, 0x10=BB, 0x11=AA; store resp_valid at N+3.
REQ-034 Byte 0x20 = 0x80; load size 1 with signed=1 -> 0xFFFFFFFFFFFFFF80; with signed=0 -> 0x0000000000000080.
REQ-035 Load size 3 from 0x0 -> err=1 at N+1; store size 8 to 1020 (MEM_BYTES=1024) -> err=1, memory unchanged.
REQ-036 Hold req_valid=1 continuously -> req_ready=0 in BEAT0/BEAT1/RESP and exactly one resp_valid per accepted request.
REQ-037 Reset pulse in BEAT1 of a split store to 0x0E -> no resp_valid, 0x0E/0x0F written, 0x10/0x11 unchanged, req_ready=1 one edge after release.
